// File: rtl/sipo_stream_pkg.sv
// Shared types and width helpers for the serial/parallel converters.
// Entry layout is data, valid-bit count and end-of-packet flag.
package usb_sipo_pkg;

    localparam int SIPO_LSB_FIRST  = 1;
    localparam int SIPO_MSB_FIRST  = 0;
    localparam int SIPO_DW_DEFAULT = 8;

    function automatic int sipo_nb_w(input int dw);
        return $clog2(dw + 1);
    endfunction

    function automatic int sipo_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int SIPO_NB_W_DEFAULT = sipo_nb_w(SIPO_DW_DEFAULT);

    typedef struct packed {
        logic [SIPO_DW_DEFAULT-1:0]   data;
        logic [SIPO_NB_W_DEFAULT-1:0] nbits;
        logic                         last;
    } sipo_entry_t;

endpackage

// File: rtl/sipo_stream_if.sv
// Serial input side and parallel valid/ready output side of sipo_stream.
// slave is the converter's view; master is the driver/consumer view.
interface sipo_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NB_W       = 4,
    parameter int LVL_W      = 3
);
    logic                  s_data_in;
    logic                  s_data_in_val;
    logic                  s_eop;
    logic                  sipo_cancel;
    logic [DATA_WIDTH-1:0] p_data_out;
    logic [NB_W-1:0]       p_data_out_nbits;
    logic                  p_data_out_last;
    logic                  p_data_out_val;
    logic                  p_data_out_rdy;
    logic                  overflow;
    logic [LVL_W-1:0]      fifo_level;

    modport slave (
        input  s_data_in, s_data_in_val, s_eop, sipo_cancel, p_data_out_rdy,
        output p_data_out, p_data_out_nbits, p_data_out_last, p_data_out_val,
               overflow, fifo_level
    );

    modport master (
        output s_data_in, s_data_in_val, s_eop, sipo_cancel, p_data_out_rdy,
        input  p_data_out, p_data_out_nbits, p_data_out_last, p_data_out_val,
               overflow, fifo_level
    );
endinterface

// File: rtl/sipo_out_fifo.sv
// First-word-fall-through FIFO; a push is visible at the head the cycle after it.
// Push while full is refused unless a pop happens in the same cycle; flush wins over both.
module sipo_out_fifo
    import usb_sipo_pkg::*;
#(
    parameter type entry_t = sipo_entry_t,
    parameter int  DEPTH   = 4,
    localparam int LVL_W   = sipo_lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  entry_t           i_wdat,
    input  logic             i_pop,
    output entry_t           o_rdat,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_level <= r_level + LVL_W'(1);
            else if (w_do_pop && !w_do_push) r_level <= r_level - LVL_W'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the level is zero.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdat;
    end

    assign o_rdat  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/sipo_stream.sv
// Serial-to-parallel accumulator feeding an FWFT FIFO; word visible the cycle after its last bit.
// Output uses valid/ready; a completed word arriving at a full, non-popping FIFO is dropped and flagged.
module sipo_stream
    import usb_sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = SIPO_LSB_FIRST,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    sipo_stream_if.slave bus
);
    localparam int NB_W  = sipo_nb_w(DATA_WIDTH);
    localparam int LVL_W = sipo_lvl_w(FIFO_DEPTH);
    localparam logic [NB_W-1:0] CNT_LAST = NB_W'(DATA_WIDTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [NB_W-1:0]       nbits;
        logic                  last;
    } entry_t;

    logic [DATA_WIDTH-1:0] r_acc;
    logic [NB_W-1:0]       r_cnt;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    entry_t                w_push_dat;
    entry_t                w_head;
    logic [LVL_W-1:0]      w_level;

    assign w_accept = bus.s_data_in_val & ~bus.sipo_cancel;
    assign w_done   = w_accept & ((r_cnt == CNT_LAST) | bus.s_eop);

    always_comb begin
        w_acc_next = r_acc;
        if (LSB_FIRST == SIPO_LSB_FIRST)
            w_acc_next = r_acc | ({DATA_WIDTH{bus.s_data_in}} & (DATA_WIDTH'(1) << r_cnt));
        else
            w_acc_next = (r_acc << 1) | DATA_WIDTH'(bus.s_data_in);
    end

    assign w_push_dat.data  = w_acc_next;
    assign w_push_dat.nbits = r_cnt + NB_W'(1);
    assign w_push_dat.last  = bus.s_eop;

    assign w_pop = ~w_empty & bus.p_data_out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (bus.sipo_cancel) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + NB_W'(1);
            end
            // The FIFO refuses this push on its own; here we only record the loss.
            if (w_done && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    sipo_out_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.sipo_cancel),
        .i_push  (w_done),
        .i_wdat  (w_push_dat),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.p_data_out       = w_head.data;
    assign bus.p_data_out_nbits = w_head.nbits;
    assign bus.p_data_out_last  = w_head.last;
    assign bus.p_data_out_val   = ~w_empty;
    assign bus.overflow         = r_overflow;
    assign bus.fifo_level       = w_level;

endmodule

// File: tb/tb_sipo_stream.sv
// Directed bench: one LSB-first and one MSB-first instance share the same serial stimulus.
module tb_sipo_stream;
    import usb_sipo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tb_bit = 1'b0, tb_val = 1'b0, tb_eop = 1'b0, tb_cancel = 1'b0, tb_rdy = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    sipo_stream_if #(.DATA_WIDTH(8), .NB_W(4), .LVL_W(3)) if_l ();
    sipo_stream_if #(.DATA_WIDTH(8), .NB_W(4), .LVL_W(3)) if_m ();

    assign if_l.s_data_in = tb_bit;   assign if_m.s_data_in = tb_bit;
    assign if_l.s_data_in_val = tb_val; assign if_m.s_data_in_val = tb_val;
    assign if_l.s_eop = tb_eop;       assign if_m.s_eop = tb_eop;
    assign if_l.sipo_cancel = tb_cancel; assign if_m.sipo_cancel = tb_cancel;
    assign if_l.p_data_out_rdy = tb_rdy; assign if_m.p_data_out_rdy = tb_rdy;

    sipo_stream #(.DATA_WIDTH(8), .LSB_FIRST(SIPO_LSB_FIRST), .FIFO_DEPTH(4)) u_lsb (
        .clk(clk), .rst(rst), .bus(if_l));
    sipo_stream #(.DATA_WIDTH(8), .LSB_FIRST(SIPO_MSB_FIRST), .FIFO_DEPTH(4)) u_msb (
        .clk(clk), .rst(rst), .bus(if_m));

    // Sends n bits of w, bit 0 first, one per cycle; eop marks the final bit when set.
    task automatic send_bits(input logic [7:0] w, input int n, input logic eop);
        logic [7:0] sh;
        sh = w;
        for (int i = 0; i < n; i++) begin
            tb_val = 1'b1;
            tb_bit = sh[0];
            tb_eop = eop && (i == n - 1);
            sh = sh >> 1;
            @(posedge clk); #1;
        end
        tb_val = 1'b0;
        tb_eop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL reset_val: got %b want 0", if_l.p_data_out_val); end
        vecs++; if (if_l.p_data_out !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", if_l.p_data_out); end
        vecs++; if (if_l.p_data_out_nbits !== 4'd0) begin errs++; $display("FAIL reset_nbits: got %0d want 0", if_l.p_data_out_nbits); end
        vecs++; if (if_l.fifo_level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", if_l.fifo_level); end
        vecs++; if (if_l.overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", if_l.overflow); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        tb_rdy = 1'b1;
        send_bits(8'h4D, 7, 1'b0);
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL basic_early_val: got %b want 0", if_l.p_data_out_val); end
        send_bits(8'h00, 1, 1'b0);
        vecs++; if (if_l.p_data_out_val !== 1'b1) begin errs++; $display("FAIL basic_val: got %b want 1", if_l.p_data_out_val); end
        vecs++; if (if_l.p_data_out !== 8'h4D) begin errs++; $display("FAIL basic_lsb_data: got %h want 4d", if_l.p_data_out); end
        vecs++; if (if_l.p_data_out_nbits !== 4'd8) begin errs++; $display("FAIL basic_nbits: got %0d want 8", if_l.p_data_out_nbits); end
        vecs++; if (if_l.p_data_out_last !== 1'b0) begin errs++; $display("FAIL basic_last: got %b want 0", if_l.p_data_out_last); end
        vecs++; if (if_m.p_data_out !== 8'hB2) begin errs++; $display("FAIL basic_msb_data: got %h want b2", if_m.p_data_out); end
        @(posedge clk); #1;
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL basic_popped_val: got %b want 0", if_l.p_data_out_val); end
        vecs++; if (if_l.p_data_out !== 8'h00) begin errs++; $display("FAIL basic_empty_data: got %h want 00", if_l.p_data_out); end
    endtask

    task automatic test_eop();
        tb_rdy = 1'b1;
        send_bits(8'b0000_0011, 3, 1'b1);
        vecs++; if (if_l.p_data_out !== 8'h03) begin errs++; $display("FAIL eop_lsb_data: got %h want 03", if_l.p_data_out); end
        vecs++; if (if_m.p_data_out !== 8'h06) begin errs++; $display("FAIL eop_msb_data: got %h want 06", if_m.p_data_out); end
        vecs++; if (if_l.p_data_out_nbits !== 4'd3) begin errs++; $display("FAIL eop_nbits: got %0d want 3", if_l.p_data_out_nbits); end
        vecs++; if (if_m.p_data_out_last !== 1'b1) begin errs++; $display("FAIL eop_last: got %b want 1", if_m.p_data_out_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_eop();
        tb_rdy = 1'b0;
        send_bits(8'hC3, 8, 1'b1);
        vecs++; if (if_l.p_data_out !== 8'hC3) begin errs++; $display("FAIL fulleop_data: got %h want c3", if_l.p_data_out); end
        vecs++; if (if_l.p_data_out_nbits !== 4'd8) begin errs++; $display("FAIL fulleop_nbits: got %0d want 8", if_l.p_data_out_nbits); end
        vecs++; if (if_l.p_data_out_last !== 1'b1) begin errs++; $display("FAIL fulleop_last: got %b want 1", if_l.p_data_out_last); end
        @(posedge clk); #1;
        vecs++; if (if_l.fifo_level !== 3'd1) begin errs++; $display("FAIL fulleop_level: got %0d want 1", if_l.fifo_level); end
        tb_rdy = 1'b1;
        @(posedge clk); #1;
        vecs++; if (if_l.fifo_level !== 3'd0) begin errs++; $display("FAIL fulleop_drain: got %0d want 0", if_l.fifo_level); end
    endtask

    task automatic test_overflow();
        logic [7:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tb_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send_bits(words[k], 8, 1'b0);
        vecs++; if (if_l.overflow !== 1'b0) begin errs++; $display("FAIL ovf_early: got %b want 0", if_l.overflow); end
        send_bits(words[4], 8, 1'b0);
        vecs++; if (if_l.overflow !== 1'b1) begin errs++; $display("FAIL ovf_lsb_flag: got %b want 1", if_l.overflow); end
        vecs++; if (if_m.overflow !== 1'b1) begin errs++; $display("FAIL ovf_msb_flag: got %b want 1", if_m.overflow); end
        vecs++; if (if_l.fifo_level !== 3'd4) begin errs++; $display("FAIL ovf_level: got %0d want 4", if_l.fifo_level); end
        tb_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vecs++; if (if_l.p_data_out !== words[k]) begin errs++; $display("FAIL ovf_order%0d: got %h want %h", k, if_l.p_data_out, words[k]); end
            @(posedge clk); #1;
        end
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL ovf_drained_val: got %b want 0", if_l.p_data_out_val); end
        vecs++; if (if_l.overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", if_l.overflow); end
    endtask

    task automatic test_cancel();
        tb_rdy = 1'b0;
        send_bits(8'h5A, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'h1F, 5, 1'b0);
        vecs++; if (if_l.fifo_level !== 3'd2) begin errs++; $display("FAIL cancel_pre_level: got %0d want 2", if_l.fifo_level); end
        tb_cancel = 1'b1; tb_val = 1'b1; tb_bit = 1'b1; tb_rdy = 1'b1;
        @(posedge clk); #1;
        tb_cancel = 1'b0; tb_val = 1'b0; tb_rdy = 1'b0;
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL cancel_val: got %b want 0", if_l.p_data_out_val); end
        vecs++; if (if_l.fifo_level !== 3'd0) begin errs++; $display("FAIL cancel_level: got %0d want 0", if_l.fifo_level); end
        vecs++; if (if_l.overflow !== 1'b0) begin errs++; $display("FAIL cancel_ovf: got %b want 0", if_l.overflow); end
        send_bits(8'hA5, 8, 1'b0);
        vecs++; if (if_l.fifo_level !== 3'd1) begin errs++; $display("FAIL cancel_after_level: got %0d want 1", if_l.fifo_level); end
        vecs++; if (if_l.p_data_out !== 8'hA5) begin errs++; $display("FAIL cancel_after_lsb: got %h want a5", if_l.p_data_out); end
        vecs++; if (if_m.p_data_out !== 8'hA5) begin errs++; $display("FAIL cancel_after_msb: got %h want a5", if_m.p_data_out); end
        vecs++; if (if_l.p_data_out_nbits !== 4'd8) begin errs++; $display("FAIL cancel_after_nbits: got %0d want 8", if_l.p_data_out_nbits); end
        tb_rdy = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        logic [15:0] stream;
        int g;
        stream = {8'hB2, 8'h4D};
        tb_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tb_val = 1'b1; tb_bit = stream[0]; stream = stream >> 1;
            @(posedge clk); #1;
            tb_val = 1'b0;
            g = $urandom_range(0, 5);
            if (g > 0) begin repeat (g) @(posedge clk); #1; end
            if (i == 11) begin
                vecs++; if (if_l.fifo_level !== 3'd1) begin errs++; $display("FAIL gap_mid_level: got %0d want 1", if_l.fifo_level); end
            end
        end
        repeat (10) @(posedge clk); #1;
        vecs++; if (if_l.fifo_level !== 3'd2) begin errs++; $display("FAIL gap_level: got %0d want 2", if_l.fifo_level); end
        tb_rdy = 1'b1;
        vecs++; if (if_l.p_data_out !== 8'h4D) begin errs++; $display("FAIL gap_w0_lsb: got %h want 4d", if_l.p_data_out); end
        vecs++; if (if_m.p_data_out !== 8'hB2) begin errs++; $display("FAIL gap_w0_msb: got %h want b2", if_m.p_data_out); end
        @(posedge clk); #1;
        vecs++; if (if_l.p_data_out !== 8'hB2) begin errs++; $display("FAIL gap_w1_lsb: got %h want b2", if_l.p_data_out); end
        vecs++; if (if_m.p_data_out !== 8'h4D) begin errs++; $display("FAIL gap_w1_msb: got %h want 4d", if_m.p_data_out); end
        @(posedge clk); #1;
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL gap_drained: got %b want 0", if_l.p_data_out_val); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words = '{8'h12, 8'h34, 8'h56};
        tb_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_bits(words[k], 8, 1'b0);
            vecs++; if (if_l.p_data_out !== words[k]) begin errs++; $display("FAIL b2b_data%0d: got %h want %h", k, if_l.p_data_out, words[k]); end
            vecs++; if (if_l.fifo_level !== 3'd1) begin errs++; $display("FAIL b2b_level%0d: got %0d want 1", k, if_l.fifo_level); end
        end
        vecs++; if (if_l.overflow !== 1'b0) begin errs++; $display("FAIL b2b_ovf: got %b want 0", if_l.overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        tb_rdy = 1'b0;
        send_bits(8'h77, 8, 1'b0);
        send_bits(8'h88, 8, 1'b0);
        send_bits(8'h05, 3, 1'b0);
        tb_rdy = 1'b1;
        #3 rst = 1'b0;
        #1;
        vecs++; if (if_l.p_data_out_val !== 1'b0) begin errs++; $display("FAIL arst_val: got %b want 0", if_l.p_data_out_val); end
        vecs++; if (if_l.p_data_out !== 8'h00) begin errs++; $display("FAIL arst_data: got %h want 00", if_l.p_data_out); end
        vecs++; if (if_l.fifo_level !== 3'd0) begin errs++; $display("FAIL arst_level: got %0d want 0", if_l.fifo_level); end
        vecs++; if (if_m.p_data_out_nbits !== 4'd0) begin errs++; $display("FAIL arst_nbits: got %0d want 0", if_m.p_data_out_nbits); end
        @(posedge clk); #1;
        rst = 1'b1;
        tb_rdy = 1'b0;
        send_bits(8'h4D, 8, 1'b0);
        vecs++; if (if_l.p_data_out !== 8'h4D) begin errs++; $display("FAIL arst_after_lsb: got %h want 4d", if_l.p_data_out); end
        vecs++; if (if_m.p_data_out !== 8'hB2) begin errs++; $display("FAIL arst_after_msb: got %h want b2", if_m.p_data_out); end
        vecs++; if (if_l.fifo_level !== 3'd1) begin errs++; $display("FAIL arst_after_level: got %0d want 1", if_l.fifo_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_eop();
        test_full_eop();
        test_overflow();
        test_cancel();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sipo_stream.md
# sipo_stream

Parametrised serial-to-parallel converter with configurable bit order, partial-word flush on end-of-packet, and a small output FIFO with valid/ready backpressure. It sits between the hub's bit-level receive path (after NRZI decode and bit-unstuffing) and the byte/word-level packet logic. It replaces the fixed two-register ping-pong `sipo` wherever downstream logic can stall or packets end on non-word boundaries.

## Interface
- `DATA_WIDTH`, default 8: parallel word width, 2..32.
- `LSB_FIRST`, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in the MSB of the valid field.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of two, 2..16.
- `NB_W`, derived as $clog2(DATA_WIDTH+1): width of bit-count fields.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_data_in` in 1: serial data bit.
- `s_data_in_val` in 1: `s_data_in` valid this cycle.
- `s_eop` in 1: the current valid bit is the last of its packet; ignored unless `s_data_in_val`=1.
- `sipo_cancel` in 1: synchronous abort; discards all in-flight and queued data.
- `p_data_out` out DATA_WIDTH: head-of-FIFO word, right-justified, zero-filled above `p_data_out_nbits`.
- `p_data_out_nbits` out NB_W: valid bits in `p_data_out`, 1..DATA_WIDTH.
- `p_data_out_last` out 1: word ends a packet.
- `p_data_out_val` out 1: head entry valid.
- `p_data_out_rdy` in 1: consumer accepts the head entry when `val`&`rdy`.
- `overflow` out 1: sticky; a completed word was dropped because the FIFO was full.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current number of queued entries.

## Operation
- Accumulator holds shift register `acc` and bit count `cnt` (0..DATA_WIDTH-1).
- On `s_data_in_val`: LSB_FIRST=1 writes the bit at `acc[cnt]`; LSB_FIRST=0 shifts left, inserting the new bit at bit 0. `cnt` increments.
- Gaps in `s_data_in_val` hold `acc`/`cnt` unchanged. Unlike `sipo`, an idle cycle does not clear state.
- A word completes when the accepted bit makes cnt+1 == DATA_WIDTH, or when `s_eop`=1 on an accepted bit. The completing bit is included.
- On completion, push {data, nbits=cnt+1, last=s_eop} and reset `acc`/`cnt` to 0. Unused upper bits are 0.
- A full-width completion that coincides with `s_eop` pushes once, with last=1.
- Push while the FIFO is full and no pop occurs in the same cycle: the word is dropped, `overflow` is set, the accumulator is still cleared, and the FIFO is unchanged.
- Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
- Push and pop in the same cycle at any level: the level is unchanged and ordering is preserved.
- `sipo_cancel`=1 clears `acc`, `cnt`, all FIFO entries, and `overflow`. It has priority over `s_data_in_val` and the pop in the same cycle.
- `overflow` clears only on reset or `sipo_cancel`.

## Timing
- Reset values: `p_data_out`=0, `p_data_out_nbits`=0, `p_data_out_last`=0, `p_data_out_val`=0, `overflow`=0, `fifo_level`=0, `acc`=0, `cnt`=0.
- Latency: completing bit accepted at edge N, FIFO previously empty → `p_data_out_val`=1 with the word after edge N (visible in cycle N+1).
- The FIFO is first-word-fall-through. Head outputs are registered or driven from the storage array, with no combinational path from `s_data_in*` to `p_data_out*`.
- `p_data_out_val` deasserts in the cycle after the last entry is popped. While `val`=0, head outputs read as 0.
- Valid/ready rules: once `val`=1, the head entry holds stable until popped or cancelled. `rdy` may toggle freely. `val` never depends combinationally on `rdy`.
- Sustained input of 1 bit per cycle produces one word every DATA_WIDTH cycles. Any FIFO_DEPTH ≥ 2 with `rdy` held at 1 never overflows.
- Reset asserted mid-word or mid-packet clears everything asynchronously. Accumulation resumes cleanly on the first valid bit after deassertion.

## Structure
- Package `usb_sipo_pkg`:
  - typedef `sipo_entry_t` {data, nbits, last}, parametrised through localparam width functions.
  - Bit-order constants `SIPO_LSB_FIRST` and `SIPO_MSB_FIRST`.
- Sub-module `sipo_out_fifo`: generic FWFT FIFO of `sipo_entry_t` with push/pop/full/empty/level and synchronous flush. Reused by the transmit-side PISO.
- Top level holds the accumulator, completion logic, overflow flag, and cancel fan-out.

## Test plan
- DATA_WIDTH=8, LSB_FIRST=1, `rdy`=1, serial bits 1,0,1,1,0,0,1,0 (first-to-last) → one word 0x4D, nbits=8, last=0, `val` high in the cycle after the 8th bit.
- Same bits with LSB_FIRST=0 → 0xB2. Then 3 bits 1,1,0 with `s_eop` on the third bit → 0x06, nbits=3, last=1 (LSB_FIRST=1 gives 0x03).
- `rdy`=0, FIFO_DEPTH=4, 40 continuous bits → 4 words queued, 5th dropped, `overflow`=1, `fifo_level`=4. Raising `rdy` pops the 4 words in order.
- Valid bits interleaved with random idle gaps of 0..5 cycles → words identical to the gap-free run, and no partial flush without `s_eop`.
- `sipo_cancel` after 5 bits with 2 words queued → next cycle `val`=0, `fifo_level`=0, `overflow`=0. The next 8 bits form a clean word.
- `rst` dropped asynchronously mid-word and mid-pop → all outputs 0 immediately. After release, the first 8 bits produce a correct word.
